// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// ID-stage hazard detector and stall controller for a 5-stage MIPS pipeline.
// Handles the hazards the EX-stage forwarding network cannot cover:
//   * load-use hazards (EX holds a load whose result the ID instruction reads)
//   * branch operands compared in ID before the producer has reached EX/MEM
// It also selects the EX/MEM forwarding path for the ID branch comparator,
// squashes the fetched instruction on a taken branch, and counts the bubble
// cycles it inserts in a saturating performance counter.
//
// Parameters
//   STALL_CNT_W       width of StallCount
//
// Ports
//   clk               rising-edge clock
//   reset_n           asynchronous active-low reset
//   ID_ExMemRead      EX instruction is a load
//   ID_ExRegWrite     EX instruction writes the register file
//   ID_ExWriteReg     EX destination register (after rt/rd select)
//   Ex_MemMemRead     MEM instruction is a load
//   Ex_MemRegWrite    MEM instruction writes the register file
//   Ex_MemRegisterRd  MEM destination register
//   IF_IdRegisterRs   rs of the ID instruction
//   IF_IdRegisterRt   rt of the ID instruction
//   IF_IdUsesRt       ID instruction reads rt
//   IF_IdBranch       ID instruction is beq/bne
//   BranchTaken       ID comparator says taken
//   ExtStall          memory wait, freezes the front end without bubbles
//   StallCountClear   synchronous clear of StallCount
//   PCWrite           PC update enable
//   IF_IdWrite        IF/ID write enable
//   ID_ExBubble       zero the ID/EX control fields
//   IF_IdFlush        squash the instruction in IF/ID
//   forwardC          comparator operand rs takes the EX/MEM ALU result
//   forwardD          comparator operand rt takes the EX/MEM ALU result
//   StallCount        saturating count of bubble cycles inserted
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ID_ExMemRead,
    input  logic                   ID_ExRegWrite,
    input  logic [4:0]             ID_ExWriteReg,
    input  logic                   Ex_MemMemRead,
    input  logic                   Ex_MemRegWrite,
    input  logic [4:0]             Ex_MemRegisterRd,
    input  logic [4:0]             IF_IdRegisterRs,
    input  logic [4:0]             IF_IdRegisterRt,
    input  logic                   IF_IdUsesRt,
    input  logic                   IF_IdBranch,
    input  logic                   BranchTaken,
    input  logic                   ExtStall,
    input  logic                   StallCountClear,
    output logic                   PCWrite,
    output logic                   IF_IdWrite,
    output logic                   ID_ExBubble,
    output logic                   IF_IdFlush,
    output logic                   forwardC,
    output logic                   forwardD,
    output logic [STALL_CNT_W-1:0] StallCount
);

    // Two-state controller: RUN evaluates hazards, HOLD plays out the
    // remaining bubbles of a multi-cycle stall without looking at inputs.
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic       state;
    logic       state_nxt;
    logic [1:0] remaining;
    logic [1:0] remaining_nxt;

    // -------------------------------------------------------------------------
    // Register matches. A producer only counts if it writes a non-zero
    // destination, so $zero can never stall or forward.
    // -------------------------------------------------------------------------
    logic ex_dest_valid;
    logic mem_dest_valid;
    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;
    logic use_ex;
    logic use_mem;

    assign ex_dest_valid  = ID_ExRegWrite  && (ID_ExWriteReg    != 5'd0);
    assign mem_dest_valid = Ex_MemRegWrite && (Ex_MemRegisterRd != 5'd0);

    assign ex_hit_rs  = ex_dest_valid  && (ID_ExWriteReg    == IF_IdRegisterRs);
    assign ex_hit_rt  = ex_dest_valid  && (ID_ExWriteReg    == IF_IdRegisterRt);
    assign mem_hit_rs = mem_dest_valid && (Ex_MemRegisterRd == IF_IdRegisterRs);
    assign mem_hit_rt = mem_dest_valid && (Ex_MemRegisterRd == IF_IdRegisterRt);

    // rt only matters when the ID instruction actually reads it.
    assign use_ex  = ex_hit_rs  || (IF_IdUsesRt && ex_hit_rt);
    assign use_mem = mem_hit_rs || (IF_IdUsesRt && mem_hit_rt);

    // -------------------------------------------------------------------------
    // Number of bubbles the ID instruction needs before it may proceed.
    // Branches resolve in ID, so they need their operands one stage earlier
    // than ALU instructions: an ALU producer in EX costs one bubble, a load
    // in EX costs two (it must reach MEM/WB), and a load in MEM costs one.
    // Non-branches only wait on a load in EX; EX forwarding covers the rest.
    // -------------------------------------------------------------------------
    logic [1:0] need;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        need = 2'd0;
        if (IF_IdBranch) begin
            if (use_ex && ID_ExMemRead) begin
                need = 2'd2;
            end else if (use_ex) begin
                need = 2'd1;
            end else if (use_mem && Ex_MemMemRead) begin
                need = 2'd1;
            end
        end else if (ID_ExMemRead && use_ex) begin
            need = 2'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Control outputs and next-state logic.
    // Priority: reset, then the external freeze, then an in-progress stall,
    // then fresh evaluation in RUN.
    // -------------------------------------------------------------------------
    always_comb begin
        PCWrite       = 1'b1;
        IF_IdWrite    = 1'b1;
        ID_ExBubble   = 1'b0;
        IF_IdFlush    = 1'b0;
        state_nxt     = state;
        remaining_nxt = remaining;

        if (!reset_n) begin
            // Pipeline held with a bubble in ID/EX while reset is asserted.
            PCWrite     = 1'b0;
            IF_IdWrite  = 1'b0;
            ID_ExBubble = 1'b1;
        end else if (ExtStall) begin
            // Memory wait: freeze everything, inject nothing, keep our state
            // so the stall sequence resumes exactly where it stopped.
            PCWrite    = 1'b0;
            IF_IdWrite = 1'b0;
        end else if (state == ST_HOLD) begin
            PCWrite     = 1'b0;
            IF_IdWrite  = 1'b0;
            ID_ExBubble = 1'b1;
            if (remaining <= 2'd1) begin
                remaining_nxt = 2'd0;
                state_nxt     = ST_RUN;
            end else begin
                remaining_nxt = remaining - 2'd1;
            end
        end else if (need != 2'd0) begin
            // First bubble is issued in the detecting cycle itself.
            PCWrite       = 1'b0;
            IF_IdWrite    = 1'b0;
            ID_ExBubble   = 1'b1;
            remaining_nxt = need - 2'd1;
            state_nxt     = (need == 2'd1) ? ST_RUN : ST_HOLD;
        end else begin
            // Branch is only allowed to squash once its operands are final.
            IF_IdFlush = IF_IdBranch && BranchTaken;
        end
    end

    // -------------------------------------------------------------------------
    // Comparator forwarding from EX/MEM. A load in MEM has no ALU result to
    // forward; that case is handled by a stall instead.
    // -------------------------------------------------------------------------
    assign forwardC = reset_n && mem_hit_rs && !Ex_MemMemRead;
    assign forwardD = reset_n && mem_hit_rt && !Ex_MemMemRead;

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state     <= ST_RUN;
            remaining <= 2'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Bubble counter: clear wins over increment, sticks at all ones.
    // ID_ExBubble is already 0 under ExtStall, so the count holds there too.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCount <= '0;
        end else if (StallCountClear) begin
            StallCount <= '0;
        end else if (ID_ExBubble && !(&StallCount)) begin
            StallCount <= StallCount + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// Bench for hazard_stall_unit. Two instances share the stimulus: the default
// 16-bit counter and a 2-bit counter for saturation. A reference model tracks
// the number of bubbles still owed and the expected counter values, computed
// from the hazard rules directly.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int CNT_W   = 16;
    localparam int SMALL_W = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ID_ExMemRead, ID_ExRegWrite;
    logic [4:0] ID_ExWriteReg;
    logic       Ex_MemMemRead, Ex_MemRegWrite;
    logic [4:0] Ex_MemRegisterRd;
    logic [4:0] IF_IdRegisterRs, IF_IdRegisterRt;
    logic       IF_IdUsesRt, IF_IdBranch, BranchTaken;
    logic       ExtStall, StallCountClear;

    logic             PCWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, forwardC, forwardD;
    logic [CNT_W-1:0] StallCount;
    logic             s_PCWrite, s_IF_IdWrite, s_ID_ExBubble, s_IF_IdFlush, s_forwardC, s_forwardD;
    logic [SMALL_W-1:0] s_StallCount;

    hazard_stall_unit #(.STALL_CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .ID_ExMemRead(ID_ExMemRead), .ID_ExRegWrite(ID_ExRegWrite), .ID_ExWriteReg(ID_ExWriteReg),
        .Ex_MemMemRead(Ex_MemMemRead), .Ex_MemRegWrite(Ex_MemRegWrite), .Ex_MemRegisterRd(Ex_MemRegisterRd),
        .IF_IdRegisterRs(IF_IdRegisterRs), .IF_IdRegisterRt(IF_IdRegisterRt), .IF_IdUsesRt(IF_IdUsesRt),
        .IF_IdBranch(IF_IdBranch), .BranchTaken(BranchTaken), .ExtStall(ExtStall),
        .StallCountClear(StallCountClear),
        .PCWrite(PCWrite), .IF_IdWrite(IF_IdWrite), .ID_ExBubble(ID_ExBubble), .IF_IdFlush(IF_IdFlush),
        .forwardC(forwardC), .forwardD(forwardD), .StallCount(StallCount)
    );

    hazard_stall_unit #(.STALL_CNT_W(SMALL_W)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .ID_ExMemRead(ID_ExMemRead), .ID_ExRegWrite(ID_ExRegWrite), .ID_ExWriteReg(ID_ExWriteReg),
        .Ex_MemMemRead(Ex_MemMemRead), .Ex_MemRegWrite(Ex_MemRegWrite), .Ex_MemRegisterRd(Ex_MemRegisterRd),
        .IF_IdRegisterRs(IF_IdRegisterRs), .IF_IdRegisterRt(IF_IdRegisterRt), .IF_IdUsesRt(IF_IdUsesRt),
        .IF_IdBranch(IF_IdBranch), .BranchTaken(BranchTaken), .ExtStall(ExtStall),
        .StallCountClear(StallCountClear),
        .PCWrite(s_PCWrite), .IF_IdWrite(s_IF_IdWrite), .ID_ExBubble(s_ID_ExBubble), .IF_IdFlush(s_IF_IdFlush),
        .forwardC(s_forwardC), .forwardD(s_forwardD), .StallCount(s_StallCount)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_pend;    // bubbles still owed after the current one
    int         m_cnt;
    int         m_cnt_s;
    int         m_need;
    bit         m_bub;
    logic [5:0] exp_ctl;   // {PCWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, forwardC, forwardD}

    // Observations
    logic [5:0]         obs_ctl;
    logic [5:0]         obs_ctl_s;
    logic [CNT_W-1:0]   obs_cnt;
    logic [SMALL_W-1:0] obs_cnt_s;

    // Set of registers the ID instruction reads contains r (r != 0)?
    function automatic bit id_reads(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (r == IF_IdRegisterRs) || (IF_IdUsesRt && r == IF_IdRegisterRt);
    endfunction

    function automatic int compute_need();
        bit ex_prod, mem_prod;
        ex_prod  = ID_ExRegWrite  && id_reads(ID_ExWriteReg);
        mem_prod = Ex_MemRegWrite && id_reads(Ex_MemRegisterRd);
        if (IF_IdBranch) begin
            if (ex_prod) return ID_ExMemRead ? 2 : 1;
            if (mem_prod && Ex_MemMemRead) return 1;
            return 0;
        end
        return (ID_ExMemRead && ex_prod) ? 1 : 0;
    endfunction

    task automatic model_eval();
        bit pc, ifw, bub, fl, fc, fd;
        m_need = compute_need();
        fc = reset_n && Ex_MemRegWrite && Ex_MemRegisterRd != 0 &&
             Ex_MemRegisterRd == IF_IdRegisterRs && !Ex_MemMemRead;
        fd = reset_n && Ex_MemRegWrite && Ex_MemRegisterRd != 0 &&
             Ex_MemRegisterRd == IF_IdRegisterRt && !Ex_MemMemRead;
        if (!reset_n)               {pc, ifw, bub, fl} = 4'b0010;
        else if (ExtStall)          {pc, ifw, bub, fl} = 4'b0000;
        else if (m_pend > 0 || m_need > 0) {pc, ifw, bub, fl} = 4'b0010;
        else                        {pc, ifw, bub, fl} = {3'b110, IF_IdBranch && BranchTaken};
        exp_ctl = {pc, ifw, bub, fl, fc, fd};
        m_bub   = bub;
    endtask

    task automatic model_tick();
        if (!reset_n) begin
            m_pend = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (!ExtStall) begin
                if (m_pend > 0)      m_pend = m_pend - 1;
                else if (m_need > 0) m_pend = m_need - 1;
            end
            if (StallCountClear) begin
                m_cnt = 0; m_cnt_s = 0;
            end else if (m_bub) begin
                if (m_cnt   < CNT_MAX)   m_cnt   = m_cnt + 1;
                if (m_cnt_s < SMALL_MAX) m_cnt_s = m_cnt_s + 1;
            end
        end
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        m_pend = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic idle_inputs();
        ID_ExMemRead = 0; ID_ExRegWrite = 0; ID_ExWriteReg = 0;
        Ex_MemMemRead = 0; Ex_MemRegWrite = 0; Ex_MemRegisterRd = 0;
        IF_IdRegisterRs = 0; IF_IdRegisterRt = 0; IF_IdUsesRt = 0;
        IF_IdBranch = 0; BranchTaken = 0; ExtStall = 0; StallCountClear = 0;
    endtask

    // One clock: sample outputs on the falling edge, advance model on the
    // rising edge, sample the counters just after it.
    task automatic run_cycle();
        @(negedge clk);
        obs_ctl   = {PCWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, forwardC, forwardD};
        obs_ctl_s = {s_PCWrite, s_IF_IdWrite, s_ID_ExBubble, s_IF_IdFlush, s_forwardC, s_forwardD};
        model_eval();
        @(posedge clk);
        model_tick();
        #1;
        obs_cnt   = StallCount;
        obs_cnt_s = s_StallCount;
    endtask

    // Clear both counters with a hazard-free cycle.
    task automatic clear_counts();
        idle_inputs();
        StallCountClear = 1;
        run_cycle();
        StallCountClear = 0;
    endtask

    // --------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        ID_ExMemRead = 1; ID_ExRegWrite = 1; ID_ExWriteReg = 5; IF_IdRegisterRs = 5;
        Ex_MemRegWrite = 1; Ex_MemRegisterRd = 5;
        assert_reset();
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            vectors++;
            if (obs_ctl !== 6'b001000 || obs_cnt !== '0 || obs_cnt_s !== '0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: ctl=%b cnt=%0d/%0d required ctl=001000 cnt=0/0",
                         i, obs_ctl, obs_cnt, obs_cnt_s);
            end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            if (i == 0) begin
                ID_ExMemRead = 1; ID_ExRegWrite = 1; ID_ExWriteReg = 5; IF_IdRegisterRs = 5;
            end
            run_cycle();
            vectors++;
            if (obs_ctl !== exp_ctl || obs_ctl[5:3] !== ((i == 0) ? 3'b001 : 3'b110)) begin
                miscompares++;
                $display("FAIL load_use cyc%0d: ctl=%b required %b", i, obs_ctl, exp_ctl);
            end
        end
        vectors++;
        if (obs_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL load_use_count: StallCount=%0d required 1", obs_cnt);
        end
    endtask

    task automatic test_branch_after_load();
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i < 2) begin
                IF_IdBranch = 1; BranchTaken = 1; IF_IdRegisterRt = 7; IF_IdUsesRt = 1;
                ID_ExMemRead = 1; ID_ExRegWrite = 1; ID_ExWriteReg = 7;
            end
            run_cycle();
            vectors++;
            if (obs_ctl !== exp_ctl || obs_ctl[5:2] !== ((i < 2) ? 4'b0010 : 4'b1100)) begin
                miscompares++;
                $display("FAIL branch_load cyc%0d: ctl=%b required %b", i, obs_ctl, exp_ctl);
            end
        end
        vectors++;
        if (obs_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL branch_load_count: StallCount=%0d required 2", obs_cnt);
        end
    endtask

    task automatic test_branch_after_alu();
        clear_counts();
        idle_inputs();
        IF_IdBranch = 1; IF_IdRegisterRs = 3; ID_ExRegWrite = 1; ID_ExWriteReg = 3;
        run_cycle();
        vectors++;
        if (obs_ctl !== exp_ctl || obs_ctl !== 6'b001000) begin
            miscompares++;
            $display("FAIL branch_alu_stall: ctl=%b required 001000", obs_ctl);
        end
        idle_inputs();
        IF_IdBranch = 1; BranchTaken = 1; IF_IdRegisterRs = 3;
        Ex_MemRegWrite = 1; Ex_MemRegisterRd = 3;
        run_cycle();
        vectors++;
        if (obs_ctl !== exp_ctl || obs_ctl !== 6'b110110 || obs_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL branch_alu_fwd: ctl=%b cnt=%0d required 110110 cnt=1", obs_ctl, obs_cnt);
        end
    endtask

    task automatic test_ext_stall_hold();
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            IF_IdBranch = 1; BranchTaken = 1; IF_IdRegisterRs = 7;
            ID_ExMemRead = 1; ID_ExRegWrite = 1; ID_ExWriteReg = 7;
            if (i >= 1 && i <= 3) ExtStall = 1;
            if (i == 5) idle_inputs();
            run_cycle();
            vectors++;
            if (obs_ctl !== exp_ctl || obs_cnt !== 16'(m_cnt) ||
                (i >= 1 && i <= 3 && (obs_ctl !== 6'b000000 || obs_cnt !== 16'd1))) begin
                miscompares++;
                $display("FAIL ext_stall cyc%0d: ctl=%b cnt=%0d required %b cnt=%0d",
                         i, obs_ctl, obs_cnt, exp_ctl, m_cnt);
            end
        end
        vectors++;
        if (obs_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL ext_stall_count: StallCount=%0d required 2", obs_cnt);
        end
    endtask

    task automatic test_reg_zero();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ID_ExMemRead = 1; ID_ExRegWrite = 1;
            if (i == 0) begin
                ID_ExWriteReg = 0; IF_IdRegisterRs = 0;
            end else if (i == 1) begin
                ID_ExWriteReg = 9; IF_IdRegisterRt = 9; IF_IdRegisterRs = 2;
            end else begin
                ID_ExMemRead = 0; Ex_MemRegWrite = 1; Ex_MemRegisterRd = 0;
                IF_IdBranch = 1;
            end
            run_cycle();
            vectors++;
            if (obs_ctl !== exp_ctl || obs_ctl !== 6'b110000) begin
                miscompares++;
                $display("FAIL reg_zero cyc%0d: ctl=%b required 110000", i, obs_ctl);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        IF_IdBranch = 1; IF_IdRegisterRs = 4;
        ID_ExMemRead = 1; ID_ExRegWrite = 1; ID_ExWriteReg = 4;
        run_cycle();   // first bubble, now in HOLD
        assert_reset();
        #1;
        vectors++;
        if ({PCWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, forwardC, forwardD} !== 6'b001000 ||
            StallCount !== '0) begin
            miscompares++;
            $display("FAIL reset_async: ctl=%b cnt=%0d required 001000 cnt=0",
                     {PCWrite, IF_IdWrite, ID_ExBubble, IF_IdFlush, forwardC, forwardD}, StallCount);
        end
        idle_inputs();
        run_cycle();
        reset_n = 1'b1;
        run_cycle();
        vectors++;
        if (obs_ctl !== exp_ctl || obs_ctl !== 6'b110000 || obs_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_hold: ctl=%b cnt=%0d required 110000 cnt=0", obs_ctl, obs_cnt);
        end
    endtask

    task automatic test_saturation();
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            ID_ExMemRead = 1; ID_ExRegWrite = 1; ID_ExWriteReg = 6; IF_IdRegisterRs = 6;
            run_cycle();
        end
        vectors++;
        if (obs_cnt_s !== 2'd3 || obs_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL saturate: cnt=%0d/%0d required 5/3", obs_cnt, obs_cnt_s);
        end
        StallCountClear = 1;
        run_cycle();
        StallCountClear = 0;
        vectors++;
        if (obs_ctl[3] !== 1'b1 || obs_cnt_s !== '0 || obs_cnt !== '0) begin
            miscompares++;
            $display("FAIL clear_priority: bubble=%b cnt=%0d/%0d required 1 cnt=0/0",
                     obs_ctl[3], obs_cnt, obs_cnt_s);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ID_ExMemRead     = ($urandom_range(0, 2) == 0);
            ID_ExRegWrite    = ($urandom_range(0, 3) != 0);
            ID_ExWriteReg    = 5'($urandom_range(0, 3));
            Ex_MemMemRead    = ($urandom_range(0, 2) == 0);
            Ex_MemRegWrite   = ($urandom_range(0, 3) != 0);
            Ex_MemRegisterRd = 5'($urandom_range(0, 3));
            IF_IdRegisterRs  = 5'($urandom_range(0, 3));
            IF_IdRegisterRt  = 5'($urandom_range(0, 3));
            IF_IdUsesRt      = 1'($urandom_range(0, 1));
            IF_IdBranch      = 1'($urandom_range(0, 1));
            BranchTaken      = 1'($urandom_range(0, 1));
            ExtStall         = ($urandom_range(0, 4) == 0);
            StallCountClear  = !ExtStall && ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 59) == 0) assert_reset();
            else reset_n = 1'b1;
            run_cycle();
            vectors++;
            if (obs_ctl !== exp_ctl || obs_ctl_s !== exp_ctl ||
                obs_cnt !== 16'(m_cnt) || obs_cnt_s !== 2'(m_cnt_s)) begin
                miscompares++;
                $display("FAIL random cyc%0d: ctl=%b/%b cnt=%0d/%0d required ctl=%b cnt=%0d/%0d",
                         i, obs_ctl, obs_ctl_s, obs_cnt, obs_cnt_s, exp_ctl, m_cnt, m_cnt_s);
            end
        end
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        m_pend = 0; m_cnt = 0; m_cnt_s = 0; m_need = 0; m_bub = 0;
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_branch_after_alu();
        test_ext_stall_hold();
        test_reg_zero();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
